// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
//
// Burst access controller that sits directly in front of a single-port
// synchronous RAM. It accepts one write or read burst command at a time and
// walks the RAM one address per cycle. Read data comes back from the RAM's
// registered data_out and is captured into a 2-entry output FIFO, which
// presents a valid/ready streaming interface to the consumer.
//
// Ports
//   clk, rst           clock shared with the RAM; rst is asynchronous, active-low
//   cmd_valid/ready    command handshake (ready only while idle)
//   cmd_wr             1 = write burst, 0 = read burst
//   cmd_addr           burst start address
//   cmd_len            beats minus one
//   wdata/_valid/_ready write beat stream (ready while in WRITE)
//   rdata/_valid/_ready read beat stream (head of the output FIFO)
//   busy               controller is not idle
//   cmd_done           one-cycle pulse when a burst completes
//   ram_data_in/addr/wr_rd  drive to the RAM port
//   ram_data_out       RAM registered output (mem[addr of previous edge])

module ram_burst_ctrl #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_wr,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  output logic [WIDTH-1:0] rdata,
  output logic             rdata_valid,
  input  logic             rdata_ready,
  output logic             busy,
  output logic             cmd_done,
  output logic [WIDTH-1:0] ram_data_in,
  output logic [AW-1:0]    ram_addr,
  output logic             ram_wr_rd,
  input  logic [WIDTH-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    cur_addr;
  logic [LEN_W-1:0] beats_left;
  logic             in_flight;
  logic             done_q;

  // Output FIFO
  logic [WIDTH-1:0] fifo_mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;

  logic             accept_cmd, accept_beat, issue, push, pop;
  logic             last_beat, drain_done;
  logic [2:0]       occ_after_pop;

  // Handshake and control decode
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    cmd_ready   = (state == IDLE);
    wdata_ready = (state == WRITE);
    busy        = (state != IDLE);
    rdata_valid = (count != 2'd0);
    rdata       = fifo_mem[rd_ptr];

    accept_cmd  = cmd_valid && cmd_ready;
    accept_beat = (state == WRITE) && wdata_valid;
    pop         = rdata_valid && rdata_ready;
    push        = in_flight;
    last_beat   = (beats_left == '0);

    // A pop in the same cycle frees a slot, which is what lets the read path
    // sustain one beat per cycle; the FIFO plus the in-flight beat can still
    // never exceed two entries.
    occ_after_pop = 3'(count) + 3'(in_flight) - 3'(pop);
    issue         = (state == READ) && (occ_after_pop < 3'd2);

    drain_done  = (state == DRAIN) && !in_flight && (count == 2'd0);

    // Write completion is registered (pulse the cycle after the last beat);
    // read completion pulses in the DRAIN->IDLE transition cycle itself.
    cmd_done    = done_q || drain_done;

    ram_addr    = cur_addr;
    ram_wr_rd   = accept_beat;
    ram_data_in = (state == WRITE) ? wdata : '0;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept_cmd) state_nxt = cmd_wr ? WRITE : READ;
      WRITE: if (accept_beat && last_beat) state_nxt = IDLE;
      READ:  if (issue && last_beat) state_nxt = DRAIN;
      DRAIN: if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, address and beat counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      beats_left <= '0;
      in_flight  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state     <= state_nxt;
      in_flight <= issue;
      done_q    <= accept_beat && last_beat;
      if (accept_cmd) begin
        cur_addr   <= cmd_addr;
        beats_left <= cmd_len;
      end else if (accept_beat || issue) begin
        // Natural modulo-2**AW wrap of the address register
        cur_addr   <= cur_addr + AW'(1);
        beats_left <= beats_left - LEN_W'(1);
      end
    end
  end

  // Output FIFO: capture happens exactly one cycle after issue, because the
  // RAM overwrites data_out on every edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the two FIFO words are reset (unlike a real RAM array) so that
      // rdata reads 0 during and after reset and stale read data from an
      // aborted burst is discarded.
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= ram_data_out;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule
